// File: rtl/slim_life_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : slim_pkg
// Description : Shared types and spawn table for the slime life controller.
// Revision    : 1.0
// ============================================================================
package slim_pkg;

    typedef enum logic [1:0] {
        SPAWN = 2'd0,
        ALIVE = 2'd1,
        DYING = 2'd2,
        WAIT  = 2'd3
    } slim_state_t;

    localparam int NUM_SLIMES = 3;

    typedef logic [9:0] tile_t;

    localparam tile_t SPAWN_ROW [NUM_SLIMES] = '{10'd10, 10'd20, 10'd28};
    localparam tile_t SPAWN_COL [NUM_SLIMES] = '{10'd5,  10'd18, 10'd30};

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/slim_life_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : slim_life_ctrl_if
// Description : Hit inputs and per-slime state outputs of the life controller.
// Revision    : 1.0
// ============================================================================
interface slim_life_ctrl_if;
    import slim_pkg::*;

    logic [NUM_SLIMES-1:0]      hit;
    logic [2:0]                 hit_dmg;
    logic                       enable;
    tile_t [NUM_SLIMES-1:0]     slim_row;
    tile_t [NUM_SLIMES-1:0]     slim_col;
    logic [NUM_SLIMES-1:0]      dead;
    logic [NUM_SLIMES-1:0]      alive;
    logic [NUM_SLIMES-1:0][2:0] slim_hp;
    logic [7:0]                 kill_count;

    modport master (
        output hit, hit_dmg, enable,
        input  slim_row, slim_col, dead, alive, slim_hp, kill_count
    );

    modport slave (
        input  hit, hit_dmg, enable,
        output slim_row, slim_col, dead, alive, slim_hp, kill_count
    );

endinterface
`default_nettype wire

// File: rtl/slim_life_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : slim_unit
// Description : One slime: life-state FSM, hit points, patrol and timers.
// Revision    : 1.0
// ============================================================================
module slim_unit
    import slim_pkg::*;
#(
    parameter int    HP_MAX         = 3,
    parameter int    DYING_FRAMES   = 48,
    parameter int    RESPAWN_FRAMES = 120,
    parameter int    MOVE_DIV       = 8,
    parameter int    COL_MIN        = 2,
    parameter int    COL_MAX        = 37,
    parameter tile_t SPAWN_R        = 10'd10,
    parameter tile_t SPAWN_C        = 10'd5
) (
    input  wire logic       frame_clk,
    input  wire logic       RESET,
    input  wire logic       i_hit,
    input  wire logic [2:0] i_hit_dmg,
    input  wire logic       i_enable,
    output tile_t           o_row,
    output tile_t           o_col,
    output logic            o_dead,
    output logic            o_alive,
    output logic [2:0]      o_hp,
    output logic            o_kill
);

    localparam int c_CNT_W = $clog2(max3(DYING_FRAMES, RESPAWN_FRAMES, MOVE_DIV) + 1);
    localparam logic [c_CNT_W-1:0] c_DYING_LAST = c_CNT_W'(DYING_FRAMES - 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST  = c_CNT_W'(RESPAWN_FRAMES - 1);
    localparam logic [c_CNT_W-1:0] c_MOVE_LAST  = c_CNT_W'(MOVE_DIV - 1);

    slim_state_t         r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_dir_right;
    tile_t               r_row;
    tile_t               r_col;
    logic [2:0]          r_hp;
    logic                r_dead;
    logic                r_alive;

    logic [3:0]          w_diff;
    logic                w_kill;

    assign w_diff = {1'b0, r_hp} - {1'b0, i_hit_dmg};
    // Kill is combinational so the top-level counter updates on the same edge as DYING entry
    assign w_kill = i_enable && (r_state == ALIVE) && i_hit && (i_hit_dmg >= r_hp);

    always_ff @(posedge frame_clk or negedge RESET) begin
        if (!RESET) begin
            r_state     <= SPAWN;
            r_cnt       <= '0;
            r_dir_right <= 1'b1;
            r_row       <= SPAWN_R;
            r_col       <= SPAWN_C;
            r_hp        <= '0;
            r_dead      <= 1'b0;
            r_alive     <= 1'b0;
        end else if (i_enable) begin
            case (r_state)
                SPAWN: begin
                    r_hp        <= 3'(HP_MAX);
                    r_row       <= SPAWN_R;
                    r_col       <= SPAWN_C;
                    r_dir_right <= 1'b1;
                    r_cnt       <= '0;
                    r_alive     <= 1'b1;
                    r_state     <= ALIVE;
                end
                ALIVE: begin
                    if (w_kill) begin
                        r_hp    <= '0;
                        r_cnt   <= '0;
                        r_dead  <= 1'b1;
                        r_alive <= 1'b0;
                        r_state <= DYING;
                    end else begin
                        if (i_hit) begin
                            r_hp <= w_diff[3] ? 3'd0 : w_diff[2:0];
                        end
                        if (r_cnt == c_MOVE_LAST) begin
                            r_cnt <= '0;
                            // At a boundary the step is spent turning around
                            if (r_dir_right) begin
                                if (r_col == tile_t'(COL_MAX)) r_dir_right <= 1'b0;
                                else                           r_col <= r_col + 10'd1;
                            end else begin
                                if (r_col == tile_t'(COL_MIN)) r_dir_right <= 1'b1;
                                else                           r_col <= r_col - 10'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                DYING: begin
                    if (r_cnt == c_DYING_LAST) begin
                        r_cnt   <= '0;
                        r_dead  <= 1'b0;
                        r_state <= WAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (r_cnt == c_WAIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= SPAWN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= SPAWN;
            endcase
        end
    end

    assign o_row   = r_row;
    assign o_col   = r_col;
    assign o_dead  = r_dead;
    assign o_alive = r_alive;
    assign o_hp    = r_hp;
    assign o_kill  = w_kill;

endmodule
`default_nettype wire

// File: rtl/slim_life_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : slim_life_ctrl
// Description : Three slime units plus the saturating kill counter.
// Revision    : 1.0
// ============================================================================
module slim_life_ctrl
    import slim_pkg::*;
#(
    parameter int HP_MAX         = 3,
    parameter int DYING_FRAMES   = 48,
    parameter int RESPAWN_FRAMES = 120,
    parameter int MOVE_DIV       = 8,
    parameter int COL_MIN        = 2,
    parameter int COL_MAX        = 37
) (
    input  wire logic       frame_clk,
    input  wire logic       RESET,
    slim_life_ctrl_if.slave bus
);

    localparam int c_SUM_W = $clog2(NUM_SLIMES + 1);

    logic [NUM_SLIMES-1:0]      w_kill;
    logic [NUM_SLIMES-1:0]      w_dead;
    logic [NUM_SLIMES-1:0]      w_alive;
    tile_t [NUM_SLIMES-1:0]     w_row;
    tile_t [NUM_SLIMES-1:0]     w_col;
    logic [NUM_SLIMES-1:0][2:0] w_hp;
    logic [c_SUM_W-1:0]         w_kill_sum;
    logic [8:0]                 w_kill_total;
    logic [7:0]                 r_kill_count;

    generate
        for (genvar g = 0; g < NUM_SLIMES; g++) begin : g_slime
            slim_unit #(
                .HP_MAX         (HP_MAX),
                .DYING_FRAMES   (DYING_FRAMES),
                .RESPAWN_FRAMES (RESPAWN_FRAMES),
                .MOVE_DIV       (MOVE_DIV),
                .COL_MIN        (COL_MIN),
                .COL_MAX        (COL_MAX),
                .SPAWN_R        (SPAWN_ROW[g]),
                .SPAWN_C        (SPAWN_COL[g])
            ) u_unit (
                .frame_clk (frame_clk),
                .RESET     (RESET),
                .i_hit     (bus.hit[g]),
                .i_hit_dmg (bus.hit_dmg),
                .i_enable  (bus.enable),
                .o_row     (w_row[g]),
                .o_col     (w_col[g]),
                .o_dead    (w_dead[g]),
                .o_alive   (w_alive[g]),
                .o_hp      (w_hp[g]),
                .o_kill    (w_kill[g])
            );
        end
    endgenerate

    always_comb begin
        w_kill_sum = '0;
        for (int i = 0; i < NUM_SLIMES; i++) begin
            w_kill_sum = w_kill_sum + c_SUM_W'(w_kill[i]);
        end
    end

    assign w_kill_total = {1'b0, r_kill_count} + 9'(w_kill_sum);

    always_ff @(posedge frame_clk or negedge RESET) begin
        if (!RESET) begin
            r_kill_count <= '0;
        end else if (w_kill_total[8]) begin
            r_kill_count <= 8'hFF;
        end else begin
            r_kill_count <= w_kill_total[7:0];
        end
    end

    assign bus.slim_row   = w_row;
    assign bus.slim_col   = w_col;
    assign bus.dead       = w_dead;
    assign bus.alive      = w_alive;
    assign bus.slim_hp    = w_hp;
    assign bus.kill_count = r_kill_count;

endmodule
`default_nettype wire

// File: doc/slim_life_ctrl.md
Name: slim_life_ctrl

Overview:
- Producer side of the slime death-animation interface: owns the state of the 3 slimes (position, hit points, life state) and drives the per-slime `dead` flags and `slim_row`/`slim_col` tile coordinates that the death-animation renderer consumes.
- Takes hit pulses from the player-attack logic, patrols live slimes horizontally, holds `dead` through the death animation, then respawns the slime after a delay.
- Runs on the frame clock, one update per video frame.

Parameters:
- HP_MAX, 3, hit points at spawn (1..7).
- DYING_FRAMES, 48, frames `dead` stays high; covers the full 5-step death animation.
- RESPAWN_FRAMES, 120, frames in WAIT before respawn (>=1).
- MOVE_DIV, 8, frames per one-tile patrol step (>=1).
- COL_MIN, 2, leftmost patrol column.
- COL_MAX, 37, rightmost patrol column (COL_MAX > COL_MIN).

Ports:
- frame_clk, in, 1, frame clock (one rising edge per video frame).
- RESET, in, 1, asynchronous, active-low reset.
- hit, in, 1x3, per-slime hit pulse, sampled on frame_clk.
- hit_dmg, in, 3, damage applied by each sampled hit.
- enable, in, 1, game running; 0 freezes all counters and states.
- slim_row, out, 10x3, tile row of each slime (renderer multiplies by 16).
- slim_col, out, 10x3, tile column of each slime.
- dead, out, 1x3, high while a slime is in DYING.
- alive, out, 1x3, high while a slime is in ALIVE.
- slim_hp, out, 3x3, current hit points.
- kill_count, out, 8, total kills, saturates at 255.

Behaviour:
- Reset (RESET low, async):
  - All slimes go to SPAWN.
  - `slim_row`/`slim_col` = SPAWN_ROW[i]/SPAWN_COL[i] from the package.
  - `slim_hp` = 0, `dead` = 0, `alive` = 0, `kill_count` = 0, direction = right, all counters 0.
  - Reset mid-DYING drops `dead` immediately, with no further frames.
- Per-slime FSM; states SPAWN, ALIVE, DYING, WAIT. All outputs are registered.
  - SPAWN: one frame. Load `slim_hp` = HP_MAX and the spawn position; direction = right; go to ALIVE.
  - ALIVE:
    - Sampled `hit[i]` with `hit_dmg` >= `slim_hp`: set `slim_hp` = 0, go to DYING, increment `kill_count`.
    - Otherwise `slim_hp` -= `hit_dmg`; `hit_dmg` = 0 leaves `slim_hp` unchanged.
    - Patrol counter counts 0..MOVE_DIV-1. On the wrap frame, `slim_col` moves ±1.
    - Direction reverses at the boundary: when the column equals COL_MAX (moving right) or COL_MIN (moving left), that step reverses direction and the column holds for that step.
    - A kill and a move on the same frame: the kill wins, the column is unchanged, and the position is frozen from then on.
  - DYING:
    - `dead[i]` = 1; the frame counter counts 0..DYING_FRAMES-1, then the slime goes to WAIT.
    - `dead` is high for exactly DYING_FRAMES frames; the first high frame is the cycle after the killing hit.
    - Position holds so the animation renders in place. Hits are ignored.
  - WAIT: `dead` = 0, `alive` = 0, position holds; after RESPAWN_FRAMES frames go to SPAWN. Hits are ignored.
- `hit[i]` outside ALIVE is ignored, with no `slim_hp` or `kill_count` change.
- Simultaneous kills on several slimes in one frame: `kill_count` adds the number of kills (0..3) and saturates at 255.
- `enable` = 0 holds every state, counter and output, with no time progress and no hits applied. Re-enabling resumes exactly where it stopped.
- Width rules:
  - `slim_hp` subtraction is done 4-bit with clamp at 0.
  - `slim_col` stays within COL_MIN..COL_MAX at all times.
  - Counter widths are $clog2(max(DYING_FRAMES, RESPAWN_FRAMES, MOVE_DIV)+1).

Decomposition:
- Package `slim_pkg`:
  - `slim_state_t` enum {SPAWN, ALIVE, DYING, WAIT}.
  - NUM_SLIMES = 3.
  - SPAWN_ROW/SPAWN_COL constant arrays, rows {10,20,28}, cols {5,18,30}.
  - `tile_t` (logic [9:0]).
- Sub-module `slim_unit`: one slime's FSM, counters, hp and position, instantiated 3× in a generate loop.
- The top level holds only `kill_count` (popcount of per-unit kill pulses) and the port fan-out.

Test Plan:
- Reset then release → all slimes SPAWN for 1 frame, then `alive` = 3'b111, `slim_hp` = 3 each, slime0 at row 10, col 5.
- `hit[0]` with `hit_dmg` = 1 three times → `slim_hp[0]` 2,1,0; `dead[0]` rises the frame after the third hit, stays high exactly 48 frames, `kill_count` = 1; `alive[0]` returns after 48+120+1 frames at col 5.
- `hit[1]` with `hit_dmg` = 5 → immediate kill, hp clamps to 0; further `hit[1]` pulses during DYING/WAIT leave `kill_count` unchanged.
- Patrol: slime2 from col 30 with MOVE_DIV = 8 → reaches col 37 after 56 frames, holds one step, then steps to 36.
- Same-frame `hit` = 3'b111 with `hit_dmg` = 7 → all `dead` high together, `kill_count` += 3; preload 254 → saturates at 255.
- RESET low at frame 20 of DYING → `dead` = 0 asynchronously; after release, normal SPAWN. `enable` = 0 for 50 frames mid-DYING → `dead` stays high 48 enabled frames in total.
